// File: rtl/bus_link_fifo.sv
// bus_link_fifo: buffered valid/ready producer->consumer link.
// DEPTH-entry in-order FIFO with occupancy output and synchronous flush.
// Optional per-entry parity (in_par/out_par/par_err) when the macro
// BUS_LINK_FIFO_PARITY_EN is defined; the default build has no parity.
module bus_link_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
`ifdef BUS_LINK_FIFO_PARITY_EN
    input  logic              in_par,
    output logic              out_par,
    output logic              par_err,
`endif
    output logic [CNT_W-1:0]  count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef BUS_LINK_FIFO_PARITY_EN
    localparam int ENT_W = DATA_W + 1;
`else
    localparam int ENT_W = DATA_W;
`endif

    logic [ENT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             push;
    logic             pop;
    logic [ENT_W-1:0] wr_entry;
    logic [ENT_W-1:0] head_entry;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1))
            return '0;
        else
            return p + 1'b1;
    endfunction

    assign in_ready  = (cnt != CNT_W'(DEPTH));
    assign out_valid = (cnt != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign count     = cnt;

`ifdef BUS_LINK_FIFO_PARITY_EN
    assign wr_entry = {in_par, in_data};
`else
    assign wr_entry = in_data;
`endif

    assign head_entry = mem[rd_ptr];

    // Head-of-queue presentation, masked to zero while empty.
    always_comb begin
        out_data = '0;
`ifdef BUS_LINK_FIFO_PARITY_EN
        out_par  = 1'b0;
`endif
        if (out_valid) begin
            out_data = head_entry[DATA_W-1:0];
`ifdef BUS_LINK_FIFO_PARITY_EN
            out_par  = head_entry[DATA_W];
`endif
        end
    end

    // Entry storage: cleared on reset, written on an accepted push unless flushed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (push && !flush) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    // Pointer and occupancy update; flush overrides any push/pop in its cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push)
                wr_ptr <= ptr_inc(wr_ptr);
            if (pop)
                rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

`ifdef BUS_LINK_FIFO_PARITY_EN
    // Sticky parity error on any accepted push with mismatching parity.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            par_err <= 1'b0;
        else if (flush)
            par_err <= 1'b0;
        else if (push && ((^in_data) != in_par))
            par_err <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_bus_link_fifo.sv
// Self-checking bench for bus_link_fifo: scoreboard queues model each link.
// Instance a uses DEPTH=4, instance b uses DEPTH=3 for the wrap test.
module tb_bus_link_fifo;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    // DEPTH=4 instance
    logic       a_flush = 1'b0;
    logic [7:0] a_in_data = '0;
    logic       a_in_valid = 1'b0;
    logic       a_in_ready;
    logic [7:0] a_out_data;
    logic       a_out_valid;
    logic       a_out_ready = 1'b0;
    logic [2:0] a_count;
`ifdef BUS_LINK_FIFO_PARITY_EN
    logic       a_in_par = 1'b0;
    logic       a_out_par;
    logic       a_par_err;
`endif

    // DEPTH=3 instance
    logic       b_flush = 1'b0;
    logic [7:0] b_in_data = '0;
    logic       b_in_valid = 1'b0;
    logic       b_in_ready;
    logic [7:0] b_out_data;
    logic       b_out_valid;
    logic       b_out_ready = 1'b0;
    logic [1:0] b_count;
`ifdef BUS_LINK_FIFO_PARITY_EN
    logic       b_in_par = 1'b0;
    logic       b_out_par;
    logic       b_par_err;
`endif

    bus_link_fifo #(.DATA_W(8), .DEPTH(4)) dut_a (
        .clk       (clk),
        .rst       (rst),
        .flush     (a_flush),
        .in_data   (a_in_data),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .out_data  (a_out_data),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
`ifdef BUS_LINK_FIFO_PARITY_EN
        .in_par    (a_in_par),
        .out_par   (a_out_par),
        .par_err   (a_par_err),
`endif
        .count     (a_count)
    );

    bus_link_fifo #(.DATA_W(8), .DEPTH(3)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .flush     (b_flush),
        .in_data   (b_in_data),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .out_data  (b_out_data),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
`ifdef BUS_LINK_FIFO_PARITY_EN
        .in_par    (b_in_par),
        .out_par   (b_out_par),
        .par_err   (b_par_err),
`endif
        .count     (b_count)
    );

    int unsigned n_chk = 0;
    int unsigned n_bad = 0;
    logic [7:0]  qa[$];
    logic [7:0]  qb[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One cycle on instance a: inputs already driven; check at negedge,
    // update the scoreboard with what the edge will do, then advance.
    task automatic step_a();
        logic [7:0] exp;
        @(negedge clk);
        check("a_count", 32'(a_count), 32'(qa.size()));
        check("a_in_ready", 32'(a_in_ready), 32'(qa.size() < 4));
        check("a_out_valid", 32'(a_out_valid), 32'(qa.size() != 0));
        if (qa.size() == 0)
            check("a_empty_data", 32'(a_out_data), 32'h0);
        else if (!(a_out_ready && !a_flush))
            check("a_head", 32'(a_out_data), 32'(qa[0]));
        if (a_flush) begin
            qa.delete();
        end else begin
            if (a_out_ready && qa.size() != 0) begin
                exp = qa.pop_front();
                check("a_pop", 32'(a_out_data), 32'(exp));
                if (a_in_valid && qa.size() < 3)
                    qa.push_back(a_in_data);
            end else if (a_in_valid && qa.size() < 4) begin
                qa.push_back(a_in_data);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int unsigned tx;
        int unsigned rx;
        int unsigned cyc;
        logic [7:0]  expb;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        qa.delete();

        // Reset values
        step_a();

        // Latency: single push into empty link
        a_in_valid = 1'b1; a_in_data = 8'hAA;
`ifdef BUS_LINK_FIFO_PARITY_EN
        a_in_par = ^a_in_data;
`endif
        step_a();
        a_in_valid = 1'b0;
        @(negedge clk);
        check("lat_valid", 32'(a_out_valid), 32'h1);
        check("lat_data", 32'(a_out_data), 32'hAA);
        check("lat_count", 32'(a_count), 32'h1);
        @(posedge clk); #1;

        // Reset mid-stream, checked before the next edge
        a_in_valid = 1'b1; a_in_data = 8'h77;
        step_a();
        #2 rst = 1'b1;
        #1;
        check("rst_count", 32'(a_count), 32'h0);
        check("rst_valid", 32'(a_out_valid), 32'h0);
        check("rst_data", 32'(a_out_data), 32'h0);
        check("rst_ready", 32'(a_in_ready), 32'h1);
        a_in_valid = 1'b0;
        qa.delete();
        @(posedge clk); #1 rst = 1'b0;
        step_a();

        // Fill to full, attempt a 5th push, then drain in order
        for (int i = 1; i <= 4; i++) begin
            a_in_valid = 1'b1; a_in_data = 8'(i);
`ifdef BUS_LINK_FIFO_PARITY_EN
            a_in_par = ^a_in_data;
`endif
            step_a();
        end
        a_in_data = 8'h05;
`ifdef BUS_LINK_FIFO_PARITY_EN
        a_in_par = ^a_in_data;
`endif
        step_a();
        check("full_ready", 32'(a_in_ready), 32'h0);
        check("full_count", 32'(a_count), 32'h4);
        // Full with simultaneous pop: push still refused this cycle
        a_out_ready = 1'b1;
        step_a();
        a_out_ready = 1'b0;
        step_a();
        check("refill_count", 32'(a_count), 32'h4);
        a_in_valid = 1'b0; a_out_ready = 1'b1;
        for (int i = 0; i < 5; i++) step_a();
        a_out_ready = 1'b0;

        // Simultaneous push and pop at count 2
        for (int i = 0; i < 2; i++) begin
            a_in_valid = 1'b1; a_in_data = 8'(8'h30 + i);
`ifdef BUS_LINK_FIFO_PARITY_EN
            a_in_par = ^a_in_data;
`endif
            step_a();
        end
        a_in_data = 8'h55; a_out_ready = 1'b1;
`ifdef BUS_LINK_FIFO_PARITY_EN
        a_in_par = ^a_in_data;
`endif
        step_a();
        check("sim_count", 32'(a_count), 32'h2);
        a_in_valid = 1'b0;
        for (int i = 0; i < 3; i++) step_a();
        a_out_ready = 1'b0;

        // Flush with a concurrent push drops everything
        for (int i = 0; i < 3; i++) begin
            a_in_valid = 1'b1; a_in_data = 8'(8'h60 + i);
`ifdef BUS_LINK_FIFO_PARITY_EN
            a_in_par = ^a_in_data;
`endif
            step_a();
        end
        a_in_data = 8'h99; a_flush = 1'b1;
        step_a();
        a_flush = 1'b0; a_in_valid = 1'b0;
        step_a();
        check("flush_count", 32'(a_count), 32'h0);
        check("flush_valid", 32'(a_out_valid), 32'h0);

`ifdef BUS_LINK_FIFO_PARITY_EN
        a_in_valid = 1'b1; a_in_data = 8'h01; a_in_par = 1'b0;
        step_a();
        a_in_valid = 1'b0;
        step_a();
        check("par_err_set", 32'(a_par_err), 32'h1);
        check("par_out", 32'(a_out_par), 32'h0);
        a_flush = 1'b1;
        step_a();
        a_flush = 1'b0;
        step_a();
        check("par_err_clr", 32'(a_par_err), 32'h0);
`endif

        // Wrap on DEPTH=3 with random consumer back-pressure
        tx = 0; rx = 0; cyc = 0;
        qb.delete();
        while (rx < 10 && cyc < 300) begin
            b_in_valid  = (tx < 10);
            b_in_data   = 8'(8'h10 + tx);
`ifdef BUS_LINK_FIFO_PARITY_EN
            b_in_par    = ^b_in_data;
`endif
            b_out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("b_count", 32'(b_count), 32'(qb.size()));
            check("b_in_ready", 32'(b_in_ready), 32'(qb.size() < 3));
            if (b_out_valid && b_out_ready) begin
                expb = (qb.size() != 0) ? qb.pop_front() : 8'hXX;
                check("b_pop", 32'(b_out_data), 32'(expb));
                check("b_order", 32'(b_out_data), 32'(8'h10 + rx));
                rx++;
            end
            if (b_in_valid && b_in_ready) begin
                qb.push_back(b_in_data);
                tx++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        b_in_valid = 1'b0; b_out_ready = 1'b0;
        check("wrap_rx", 32'(rx), 32'd10);
        check("wrap_left", 32'(qb.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
